// File: rtl/tx_port_scheduler.sv
// Round-robin scheduler granting one transmit manager at a time to the shared output port.
// Optional stall watchdog enabled with `define SCHED_TIMEOUT_EN.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 16
`endif

module tx_port_scheduler #(
  parameter int unsigned PORT_NUB     = `PORT_NUB_TOTAL,
  parameter int unsigned WIDTH_SEL    = $clog2(PORT_NUB),
  parameter int unsigned WIDTH_LENGTH = $clog2(`DATA_LENGTH_MAX),
  parameter int unsigned TIMEOUT      = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_NUB-1:0]              req,
  input  logic [PORT_NUB*WIDTH_LENGTH-1:0] len_in,
  input  logic                             keep_in,
  output logic [PORT_NUB-1:0]              grant,
  output logic [WIDTH_SEL-1:0]             grant_nub,
  output logic                             grant_valid,
  output logic                             last,
  output logic [PORT_NUB-1:0]              done,
  output logic                             busy,
  output logic                             err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [WIDTH_SEL-1:0]    ptr_q, ptr_d;
  logic [WIDTH_LENGTH-1:0] cnt_q, cnt_d;
  logic [PORT_NUB-1:0]     grant_q, grant_d;
  logic [WIDTH_SEL-1:0]    nub_q, nub_d;
  logic                    valid_q, valid_d;
  logic [PORT_NUB-1:0]     done_q, done_d;

  logic                    win_found;
  logic [WIDTH_SEL-1:0]    win_idx;
  logic [WIDTH_SEL-1:0]    cand;
  logic [WIDTH_LENGTH-1:0] win_len;
  int unsigned             pos;
  logic                    timeout_hit;

  // First requesting port at or after ptr, wrapping past the top index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    cand      = '0;
    for (int k = 0; k < int'(PORT_NUB); k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= PORT_NUB) pos = pos - PORT_NUB;
      cand = WIDTH_SEL'(pos);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_len = '0;
    for (int i = 0; i < int'(PORT_NUB); i++) begin
      if (WIDTH_SEL'(i) == win_idx) win_len = len_in[i*WIDTH_LENGTH +: WIDTH_LENGTH];
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q;

  assign timeout_hit = (state_q == ST_RUN) && keep_in && (stall_q == STALL_W'(TIMEOUT - 1));

  // Stall counter restarts on every transferred beat and on each new grant.
  always_comb begin
    stall_d = stall_q;
    if (state_q != ST_RUN || !keep_in || timeout_hit) stall_d = '0;
    else stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    nub_d   = nub_q;
    valid_d = valid_q;
    done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_RUN;
          grant_d = PORT_NUB'(1) << win_idx;
          nub_d   = win_idx;
          valid_d = 1'b1;
          cnt_d   = win_len;
          ptr_d   = (win_idx == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : win_idx + WIDTH_SEL'(1);
        end
      end
      ST_RUN: begin
        // cnt counts remaining beats after the current one; zero marks the last beat.
        if ((!keep_in && cnt_q == '0) || timeout_hit) begin
          state_d = ST_IDLE;
          grant_d = '0;
          nub_d   = '0;
          valid_d = 1'b0;
          done_d  = grant_q;
        end else if (!keep_in) begin
          cnt_d = cnt_q - WIDTH_LENGTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      nub_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      nub_q   <= nub_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign grant       = grant_q;
  assign grant_nub   = nub_q;
  assign grant_valid = valid_q;
  assign done        = done_q;
  assign last        = valid_q && (cnt_q == '0);
  assign busy        = (state_q == ST_RUN);

endmodule

// File: doc/tx_port_scheduler.md
# tx_port_scheduler

Round-robin scheduler that shares one switch output port among the `PORT_NUB` per-input transmit managers. Each manager raises a request with the payload length of its head packet. The scheduler grants exactly one manager at a time, counts the packet's beats against downstream backpressure, and then releases the port with a per-port done pulse. It sits between the transmit managers and the output mux, and drives the mux select.

## Interface

Parameters:
- `PORT_NUB`, default `` `PORT_NUB_TOTAL `` (8): number of requesters.
- `WIDTH_SEL`, default `$clog2(PORT_NUB)`: width of the port index.
- `WIDTH_LENGTH`, default `` $clog2(`DATA_LENGTH_MAX) ``: width of the payload-length field.
- `TIMEOUT`, default 256: stall limit in cycles. Used only with `SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  `PORT_NUB`: request vector, one bit per port; level-sensitive.
- `len_in`  in  `PORT_NUB*WIDTH_LENGTH`: payload length per port; port i uses bits [i*WIDTH_LENGTH +: WIDTH_LENGTH].
- `keep_in`  in  1: downstream stall; no beat transfers in a cycle where it is high.
- `grant`  out  `PORT_NUB`: one-hot grant.
- `grant_nub`  out  `WIDTH_SEL`: index of the granted port; drives the mux select.
- `grant_valid`  out  1: a grant is active.
- `last`  out  1: the current beat is the final beat of the packet.
- `done`  out  `PORT_NUB`: one-cycle release pulse for the port whose packet finished.
- `busy`  out  1: the FSM is not in IDLE.
- `err`  out  1: one-cycle pulse when the watchdog forces a release.

## Operation

- FSM states: IDLE and RUN.
- IDLE:
  - If `req` is nonzero, select winner w: the first set bit at or after `ptr`, searching upward and wrapping from `PORT_NUB-1` to 0.
  - On the next edge: state becomes RUN, `grant` becomes one-hot w, `grant_nub` becomes w, `grant_valid` becomes 1, `cnt` is loaded with `len_in[w]` sampled in the IDLE cycle, and `ptr` becomes (w+1) mod `PORT_NUB`.
- RUN:
  - In each cycle with `keep_in`=0, one beat transfers.
  - If `cnt`=0, that beat is the last one. On the next edge: state returns to IDLE, `grant`, `grant_nub` and `grant_valid` clear, and `done[w]` is set for one cycle.
  - Otherwise `cnt` decrements by 1.
  - If `keep_in`=1, nothing changes.
- Beat count: a packet occupies `len_in`+1 beats (header plus payload). `len_in`=0 gives a single beat.
- `last` = `grant_valid` AND (`cnt`==0). It is decoded from registers, not from inputs.
- `busy` = (state==RUN).
- Changes to `req` or `len_in` during RUN are ignored. A grant cannot be revoked except by reset or the watchdog.
- Requests that lose arbitration stay pending as long as `req` is held. No request is latched internally.
- `cnt` is `WIDTH_LENGTH` bits wide. It is never decremented below 0, so no wrap-around occurs.
- `ptr` reset value is 0, so port 0 has highest priority after reset.

## Timing

- Reset values (asynchronous, applied immediately, also mid-packet):
  - state=IDLE, `ptr`=0, `cnt`=0.
  - `grant`=0, `grant_nub`=0, `grant_valid`=0, `last`=0, `done`=0, `busy`=0, `err`=0.
- Arbitration latency: `req` high in cycle T gives `grant` in cycle T+1.
- Packet duration: the grant lasts `len_in`+1 cycles plus the number of stall cycles.
- Done: the `done` pulse coincides with the first IDLE cycle after the last beat. That same cycle is also the arbitration cycle for the next grant.
- Gap: minimum of one idle cycle between consecutive grants. Peak utilisation is (L+1)/(L+2).
- `keep_in` high in the final beat cycle delays release until `keep_in` drops.

## Configuration

- With `SCHED_TIMEOUT_EN` defined:
  - A stall counter of `$clog2(TIMEOUT+1)` bits is added. It clears on every transferred beat and on entry to RUN.
  - It counts RUN cycles with `keep_in`=1.
  - When it reaches `TIMEOUT`: forced return to IDLE, `done[w]` pulses, and `err` pulses in the same cycle.
- Without `SCHED_TIMEOUT_EN`:
  - No stall counter is built and `err` is tied to 0.
  - RUN waits on `keep_in` indefinitely.

## Test plan

Bench configuration: `PORT_NUB`=4, `WIDTH_LENGTH`=4.

1. Reset release, `req`=0001, `len_in[0]`=3, `keep_in`=0 → `grant`=0001 for 4 cycles; `last` high in the 4th; `done`=0001 in the 5th; `ptr`=1.
2. `req`=1111 held, every length 0 → grants in order 0,1,2,3,0, each 1 cycle, separated by 1 idle cycle; `done` pulses follow the same order.
3. `req`=0101, `len_in[0]`=2, `keep_in` high for 3 cycles mid-packet → `grant` lasts 6 cycles; `cnt` holds during the stall; port 2 is granted after port 0's done.
4. Assert `rst` while `cnt`=5 during a port-1 grant → all outputs 0 immediately; after release with `req`=0010, port 1 is granted first, because `ptr`=0 and no lower port is requesting.
5. `req[3]` dropped during port 3's RUN with `len_in`=4 → grant still completes all 5 beats and `done`=1000.
6. With `SCHED_TIMEOUT_EN` and `TIMEOUT`=8, `keep_in` held high after the grant → release 8 stalled cycles later with `err`=1 and `done[w]`=1 in the same cycle; without the macro the grant persists and `err` stays 0.
